param_issue_queue: RTL
======================

// Module: param_issue_queue
// PURPOSE
//  Parametrised unified issue queue (reservation station) for the RISC-V OoO core. It sits between rename/dispatch and the FUs.
//  - Holds up to RS_DEPTH renamed instructions.
//  - Captures operand values from NUM_WB writeback broadcast ports.
//  - Issues up to NUM_FU instructions per cycle, oldest-ready-first, one per FU.
//  - Adds a dispatch ready/valid handshake and a pipeline flush.
// PARAMETERS
//  RS_DEPTH  16  entries; power of two, 4..64
//  PREG_W    7   physical register tag width; tag 0 = x0
//  XLEN      32  operand/immediate width
//  NUM_FU    3   issue ports; FU index doubles as FU type
//  FU_W      2   width of fu_type_in, >= clog2(NUM_FU)
//  NUM_WB    2   writeback/wakeup broadcast ports
// PORTS
//  clk                 in   1              rising-edge clock
//  rstn                in   1              async active-low reset
//  flush_in            in   1              synchronous flush; invalidates every entry
//  disp_valid_in       in   1              dispatch request
//  disp_ready_out      out  1              at least one free entry
//  disp_fu_type_in     in   FU_W           target FU index
//  disp_ctrl_in        in   17             {funct7, funct3, opcode}, passed through unchanged
//  disp_rs1_in         in   PREG_W         rs1 tag
//  disp_rs1_rdy_in     in   1              rs1 value valid at dispatch
//  disp_rs1_val_in     in   XLEN           rs1 value
//  disp_rs2_in         in   PREG_W         rs2 tag
//  disp_rs2_rdy_in     in   1              rs2 value valid at dispatch
//  disp_rs2_val_in     in   XLEN           rs2 value
//  disp_imm_in         in   XLEN           immediate
//  disp_rd_in          in   PREG_W         destination tag
//  wb_valid_in         in   NUM_WB         broadcast valid, per port
//  wb_tag_in           in   NUM_WB*PREG_W  broadcast tags
//  wb_val_in           in   NUM_WB*XLEN    broadcast values
//  fu_ready_in         in   NUM_FU         FU f accepts an instruction this cycle
//  iss_valid_out       out  NUM_FU         issue valid, per FU (registered)
//  iss_ctrl_out        out  NUM_FU*17      issued {funct7, funct3, opcode}
//  iss_rs1_val_out     out  NUM_FU*XLEN    issued rs1 value
//  iss_rs2_val_out     out  NUM_FU*XLEN    issued rs2 value
//  iss_imm_out         out  NUM_FU*XLEN    issued immediate
//  iss_rd_out          out  NUM_FU*PREG_W  issued destination tag
//  occupancy_out       out  clog2(RS_DEPTH)+1  number of valid entries
// BEHAVIOUR
//  - Reset (rstn low, async): all entries invalid; age matrix cleared.
//    All outputs 0, except disp_ready_out = 1.
//  - Dispatch: accepted at a rising edge when disp_valid_in && disp_ready_out.
//    Written to the lowest-index free entry; the entry becomes younger than every valid entry.
//  - disp_ready_out = (occupancy_out < RS_DEPTH). It is registered, so an entry freed by issue at edge E is allocatable only after E.
//  - Operand ready at capture:
//    - tag 0: ready, value 0;
//    - else disp_rsX_rdy_in;
//    - else a same-cycle wb match on that tag (bypass). The lowest wb port wins.
//  - Wakeup: each valid, not-ready operand compares its tag with every valid wb port.
//    On a match at edge E it latches the value and sets ready. The entry is selectable for the issue at edge E+1.
//  - Select (combinational, per FU f): candidates are entries with valid && rs1_rdy && rs2_rdy && fu_type == f. Pick the oldest via the age matrix.
//  - Issue: if a candidate exists and fu_ready_in[f], then at the edge:
//    - iss_*_out[f] are loaded and iss_valid_out[f] = 1;
//    - the entry is freed.
//    Otherwise iss_valid_out[f] = 0 and payload outputs hold.
//  - Latency: best case is dispatch at E, issue outputs valid after E+1.
//  - Structural limits: one issue per FU per cycle; different FUs never select the same entry, because types are disjoint.
//  - Simultaneous events:
//    - dispatch + issue same edge: both happen; occupancy net 0;
//    - wakeup + dispatch of a consumer: bypass rule above;
//    - flush + anything: flush wins. All entries are invalidated, iss_valid_out = 0 next cycle, and the dispatch is dropped.
//  - Full: disp_valid_in with disp_ready_out = 0 is ignored. The dispatcher must hold the request.
//  - Reset mid-operation: state is lost immediately; no issue after rstn rises until a new dispatch.
//  - Widths: occupancy is clog2(RS_DEPTH)+1 bits and never wraps. Tags and values are never modified.
// STRUCTURE
//  - iq_pkg: XLEN, PREG_W defaults, CTRL_W = 17, entry field layout (valid, fu_type, ctrl, tags, rdy bits, values, imm, rd).
//  - One sub-module, iq_oldest_select: parameters RS_DEPTH; inputs req vector + age matrix; outputs one-hot grant + any.
//    Instantiated NUM_FU times.
//  - Top level: entry array, age matrix (row i = older-than bits), wakeup CAM, alloc priority encoder, output registers.
// TESTING
//  1. Reset / basic issue:
//     - stimulus: pulse rstn low at 1 ns; then dispatch add (fu 0, rs1 = 5 rdy val 1, rs2 = 2 rdy val 1, rd = 4); fu_ready = 3'b111;
//     - required: iss_valid_out[0] = 1 one edge after dispatch, rs1/rs2 val = 1/1, rd = 4; occupancy 1 -> 0.
//  2. Wakeup:
//     - stimulus: dispatch fu 1 with rs1 = 9 not ready; wb port 1 tag 9 val 32'hDEAD two cycles later;
//     - required: issue on FU1 exactly one edge after the wb edge, rs1 val = 32'hDEAD.
//  3. Bypass:
//     - stimulus: dispatch rs2 = 12 not ready in the same cycle as wb port 0 tag 12 val 7;
//     - required: issues next edge with rs2 val 7.
//  4. Age order:
//     - stimulus: fu_ready[2] = 0; dispatch A, B, C to fu 2, all ready; raise fu_ready[2];
//     - required: issue order A, B, C on consecutive edges, even when C sits in a lower free index.
//  5. Full:
//     - stimulus: fill 16 entries, fu_ready = 0;
//     - required: disp_ready_out = 0, a 17th dispatch is dropped, occupancy = 16.
//       After one issue, disp_ready_out returns to 1 on the next cycle.
//  6. Flush:
//     - stimulus: assert flush_in with 5 entries and a dispatch pending;
//     - required: occupancy 0 and iss_valid_out = 0 next cycle; the flushed entries never issue.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared widths and operand-source encoding for the unified issue queue.
package iq_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int PREG_W_DEF = 7;
  localparam int CTRL_W     = 17;

  // Where a dispatched operand's value comes from at capture time.
  typedef enum logic [1:0] {
    OP_WAIT,
    OP_ZERO,
    OP_READY,
    OP_BYPASS
  } op_src_e;

endpackage

// File: rtl/iq_oldest_select.sv
// Oldest-requester picker: grants the requester with no older requester per the age matrix.
module iq_oldest_select
  import iq_pkg::*;
#(
  parameter int RS_DEPTH = 16
) (
  input  logic [RS_DEPTH-1:0]               req,
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age,
  output logic [RS_DEPTH-1:0]               grant,
  output logic                              any
);

  // age[i][j] = 1 means entry j is older than entry i.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      grant[i] = req[i] && ((req & age[i]) == '0);
    end
    any = |req;
  end

endmodule

// File: rtl/param_issue_queue.sv
// Unified issue queue: wakeup CAM, oldest-ready select per FU, registered issue outputs.
module param_issue_queue
  import iq_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int PREG_W   = PREG_W_DEF,
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_FU   = 3,
  parameter int FU_W     = 2,
  parameter int NUM_WB   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush_in,
  input  logic                       disp_valid_in,
  output logic                       disp_ready_out,
  input  logic [FU_W-1:0]            disp_fu_type_in,
  input  logic [CTRL_W-1:0]          disp_ctrl_in,
  input  logic [PREG_W-1:0]          disp_rs1_in,
  input  logic                       disp_rs1_rdy_in,
  input  logic [XLEN-1:0]            disp_rs1_val_in,
  input  logic [PREG_W-1:0]          disp_rs2_in,
  input  logic                       disp_rs2_rdy_in,
  input  logic [XLEN-1:0]            disp_rs2_val_in,
  input  logic [XLEN-1:0]            disp_imm_in,
  input  logic [PREG_W-1:0]          disp_rd_in,
  input  logic [NUM_WB-1:0]          wb_valid_in,
  input  logic [NUM_WB*PREG_W-1:0]   wb_tag_in,
  input  logic [NUM_WB*XLEN-1:0]     wb_val_in,
  input  logic [NUM_FU-1:0]          fu_ready_in,
  output logic [NUM_FU-1:0]          iss_valid_out,
  output logic [NUM_FU*CTRL_W-1:0]   iss_ctrl_out,
  output logic [NUM_FU*XLEN-1:0]     iss_rs1_val_out,
  output logic [NUM_FU*XLEN-1:0]     iss_rs2_val_out,
  output logic [NUM_FU*XLEN-1:0]     iss_imm_out,
  output logic [NUM_FU*PREG_W-1:0]   iss_rd_out,
  output logic [$clog2(RS_DEPTH):0]  occupancy_out
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int OCC_W = IDX_W + 1;

  // Entry field layout; widths follow the instance parameters.
  typedef struct packed {
    logic              valid;
    logic [FU_W-1:0]   fu_type;
    logic [CTRL_W-1:0] ctrl;
    logic [PREG_W-1:0] rs1;
    logic              rs1_rdy;
    logic [XLEN-1:0]   rs1_val;
    logic [PREG_W-1:0] rs2;
    logic              rs2_rdy;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [PREG_W-1:0] rd;
  } entry_t;

  entry_t                            ent_q [RS_DEPTH];
  entry_t                            ent_d [RS_DEPTH];
  entry_t                            new_ent;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
  logic [RS_DEPTH-1:0]               valid_q;
  logic [RS_DEPTH-1:0]               free_mask;
  logic [IDX_W-1:0]                  alloc_idx;
  logic                              alloc_found;
  logic                              do_alloc;
  logic [OCC_W-1:0]                  occ_d;

  logic [PREG_W-1:0] wb_tag [NUM_WB];
  logic [XLEN-1:0]   wb_val [NUM_WB];

  logic [PREG_W-1:0] d_tag   [2];
  logic              d_rdy   [2];
  logic [XLEN-1:0]   d_val   [2];
  op_src_e           cap_src [2];
  logic [XLEN-1:0]   bp_val  [2];
  logic              cap_rdy [2];
  logic [XLEN-1:0]   cap_val [2];

  logic [RS_DEPTH-1:0] req   [NUM_FU];
  logic [RS_DEPTH-1:0] grant [NUM_FU];
  logic [NUM_FU-1:0]   any_sel;
  logic [NUM_FU-1:0]   fire;

  logic [CTRL_W-1:0] sel_ctrl [NUM_FU];
  logic [XLEN-1:0]   sel_rs1  [NUM_FU];
  logic [XLEN-1:0]   sel_rs2  [NUM_FU];
  logic [XLEN-1:0]   sel_imm  [NUM_FU];
  logic [PREG_W-1:0] sel_rd   [NUM_FU];

  logic [CTRL_W-1:0] iss_ctrl_q [NUM_FU];
  logic [XLEN-1:0]   iss_rs1_q  [NUM_FU];
  logic [XLEN-1:0]   iss_rs2_q  [NUM_FU];
  logic [XLEN-1:0]   iss_imm_q  [NUM_FU];
  logic [PREG_W-1:0] iss_rd_q   [NUM_FU];

  always_comb begin
    for (int unsigned w = 0; w < NUM_WB; w++) begin
      wb_tag[w] = wb_tag_in[w*PREG_W +: PREG_W];
      wb_val[w] = wb_val_in[w*XLEN +: XLEN];
    end
  end

  // Operand capture: x0, then dispatch-ready, then same-cycle broadcast (lowest port wins).
  always_comb begin
    d_tag[0] = disp_rs1_in;  d_rdy[0] = disp_rs1_rdy_in;  d_val[0] = disp_rs1_val_in;
    d_tag[1] = disp_rs2_in;  d_rdy[1] = disp_rs2_rdy_in;  d_val[1] = disp_rs2_val_in;
    for (int unsigned op = 0; op < 2; op++) begin
      cap_src[op] = OP_WAIT;
      bp_val[op]  = '0;
      for (int unsigned w = NUM_WB; w > 0; w--) begin
        if (wb_valid_in[w-1] && (wb_tag[w-1] == d_tag[op])) begin
          cap_src[op] = OP_BYPASS;
          bp_val[op]  = wb_val[w-1];
        end
      end
      if (d_rdy[op])          cap_src[op] = OP_READY;
      if (d_tag[op] == '0)    cap_src[op] = OP_ZERO;
      case (cap_src[op])
        OP_ZERO:   begin cap_rdy[op] = 1'b1; cap_val[op] = '0;        end
        OP_READY:  begin cap_rdy[op] = 1'b1; cap_val[op] = d_val[op]; end
        OP_BYPASS: begin cap_rdy[op] = 1'b1; cap_val[op] = bp_val[op]; end
        default:   begin cap_rdy[op] = 1'b0; cap_val[op] = '0;        end
      endcase
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.fu_type = disp_fu_type_in;
    new_ent.ctrl    = disp_ctrl_in;
    new_ent.rs1     = disp_rs1_in;
    new_ent.rs1_rdy = cap_rdy[0];
    new_ent.rs1_val = cap_val[0];
    new_ent.rs2     = disp_rs2_in;
    new_ent.rs2_rdy = cap_rdy[1];
    new_ent.rs2_val = cap_val[1];
    new_ent.imm     = disp_imm_in;
    new_ent.rd      = disp_rd_in;
  end

  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      valid_q[i] = ent_q[i].valid;
      if (!ent_q[i].valid && !alloc_found) begin
        alloc_idx   = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  assign do_alloc = disp_valid_in && disp_ready_out;

  always_comb begin
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      req[f] = '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        req[f][i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy &&
                    (ent_q[i].fu_type == FU_W'(f));
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    iq_oldest_select #(
      .RS_DEPTH (RS_DEPTH)
    ) u_sel (
      .req   (req[f]),
      .age   (age_q),
      .grant (grant[f]),
      .any   (any_sel[f])
    );
  end

  always_comb begin
    free_mask = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      fire[f]     = any_sel[f] && fu_ready_in[f];
      sel_ctrl[f] = '0;
      sel_rs1[f]  = '0;
      sel_rs2[f]  = '0;
      sel_imm[f]  = '0;
      sel_rd[f]   = '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (grant[f][i]) begin
          sel_ctrl[f] |= ent_q[i].ctrl;
          sel_rs1[f]  |= ent_q[i].rs1_val;
          sel_rs2[f]  |= ent_q[i].rs2_val;
          sel_imm[f]  |= ent_q[i].imm;
          sel_rd[f]   |= ent_q[i].rd;
        end
      end
      if (fire[f]) free_mask |= grant[f];
    end
  end

  always_comb begin
    ent_d = ent_q;
    age_d = age_q;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      for (int unsigned w = NUM_WB; w > 0; w--) begin
        if (ent_q[i].valid && wb_valid_in[w-1]) begin
          if (!ent_q[i].rs1_rdy && (ent_q[i].rs1 == wb_tag[w-1])) begin
            ent_d[i].rs1_rdy = 1'b1;
            ent_d[i].rs1_val = wb_val[w-1];
          end
          if (!ent_q[i].rs2_rdy && (ent_q[i].rs2 == wb_tag[w-1])) begin
            ent_d[i].rs2_rdy = 1'b1;
            ent_d[i].rs2_val = wb_val[w-1];
          end
        end
      end
      if (free_mask[i]) ent_d[i].valid = 1'b0;
    end
    // New entry is younger than all survivors; clearing its column also scrubs stale bits from its previous life.
    if (do_alloc) begin
      ent_d[alloc_idx] = new_ent;
      for (int unsigned j = 0; j < RS_DEPTH; j++) age_d[j][alloc_idx] = 1'b0;
      age_d[alloc_idx] = valid_q & ~free_mask;
    end
    if (flush_in) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) ent_d[i].valid = 1'b0;
      age_d = '0;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(ent_d[i].valid);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
      age_q          <= '0;
      occupancy_out  <= '0;
      disp_ready_out <= 1'b1;
      iss_valid_out  <= '0;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        iss_ctrl_q[f] <= '0;
        iss_rs1_q[f]  <= '0;
        iss_rs2_q[f]  <= '0;
        iss_imm_q[f]  <= '0;
        iss_rd_q[f]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
      age_q          <= age_d;
      occupancy_out  <= occ_d;
      disp_ready_out <= (occ_d < OCC_W'(RS_DEPTH));
      iss_valid_out  <= flush_in ? '0 : fire;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (fire[f] && !flush_in) begin
          iss_ctrl_q[f] <= sel_ctrl[f];
          iss_rs1_q[f]  <= sel_rs1[f];
          iss_rs2_q[f]  <= sel_rs2[f];
          iss_imm_q[f]  <= sel_imm[f];
          iss_rd_q[f]   <= sel_rd[f];
        end
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_out
    assign iss_ctrl_out[f*CTRL_W +: CTRL_W]  = iss_ctrl_q[f];
    assign iss_rs1_val_out[f*XLEN +: XLEN]   = iss_rs1_q[f];
    assign iss_rs2_val_out[f*XLEN +: XLEN]   = iss_rs2_q[f];
    assign iss_imm_out[f*XLEN +: XLEN]       = iss_imm_q[f];
    assign iss_rd_out[f*PREG_W +: PREG_W]    = iss_rd_q[f];
  end

endmodule
